// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: per-stage write/flush, dmem wait timeout.
// Optional perf counters enabled by defining HAZARD_PERF_COUNT_EN.
module hazard_controller #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [31:0] IFID_ir_i,
  input  logic [31:0] IDEX_ir_i,
  input  logic [1:0]  IDEX_ctrl_mem_read_i,
  input  logic        EXMEM_ctrl_branch_i,
  input  logic        EXMEM_alu_do_branch_i,
  input  logic [1:0]  EXMEM_ctrl_mem_read_i,
  input  logic [1:0]  EXMEM_ctrl_mem_write_i,
  input  logic        imem_ready_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        IFID_write_o,
  output logic        IFID_flush_o,
  output logic        IDEX_write_o,
  output logic        IDEX_flush_o,
  output logic        EXMEM_write_o,
  output logic        EXMEM_flush_o,
  output logic        MEMWB_write_o,
  output logic        halt_o,
  output logic        timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WAIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic [4:0] idex_rt;
  logic       unused_ir_bits;

  assign ifid_rs = IFID_ir_i[25:21];
  assign ifid_rt = IFID_ir_i[20:16];
  assign idex_rt = IDEX_ir_i[20:16];
  assign unused_ir_bits = ^{IFID_ir_i[31:26], IFID_ir_i[15:0],
                            IDEX_ir_i[31:21], IDEX_ir_i[15:0]};

  logic mem_stall;
  logic br_taken;
  logic load_use;
  logic if_stall;

  assign mem_stall = ((EXMEM_ctrl_mem_read_i != 2'd0) |
                      (EXMEM_ctrl_mem_write_i != 2'd0)) & ~dmem_ready_i;
  assign br_taken  = EXMEM_ctrl_branch_i & EXMEM_alu_do_branch_i;
  assign load_use  = (IDEX_ctrl_mem_read_i != 2'd0) & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  assign if_stall  = ~imem_ready_i;

  // Priority is flattened into exclusive selects so the decoder stays unique.
  logic halted;
  logic sel_mem;
  logic sel_br;
  logic sel_lu;
  logic sel_if;

  assign halted  = (state == HALT);
  assign sel_mem = ~halted & mem_stall;
  assign sel_br  = ~halted & ~mem_stall & br_taken;
  assign sel_lu  = ~halted & ~mem_stall & ~br_taken & load_use;
  assign sel_if  = ~halted & ~mem_stall & ~br_taken & ~load_use & if_stall;

  always_comb begin
    pc_write_o    = 1'b1;
    pc_src_o      = 1'b0;
    IFID_write_o  = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_write_o  = 1'b1;
    IDEX_flush_o  = 1'b0;
    EXMEM_write_o = 1'b1;
    EXMEM_flush_o = 1'b0;
    MEMWB_write_o = 1'b1;
    unique case (1'b1)
      halted, sel_mem: begin
        pc_write_o    = 1'b0;
        IFID_write_o  = 1'b0;
        IDEX_write_o  = 1'b0;
        EXMEM_write_o = 1'b0;
        MEMWB_write_o = 1'b0;
      end
      sel_br: begin
        pc_src_o      = 1'b1;
        IFID_flush_o  = 1'b1;
        IDEX_flush_o  = 1'b1;
        EXMEM_flush_o = 1'b1;
      end
      sel_lu: begin
        pc_write_o   = 1'b0;
        IFID_write_o = 1'b0;
        IDEX_flush_o = 1'b1;
      end
      sel_if: begin
        pc_write_o   = 1'b0;
        IFID_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      halt_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt < MAX_W) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end else begin
            state     <= HALT;
            halt_o    <= 1'b1;
            timeout_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNT_EN
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!halted && !pc_write_o && stall_cnt_o != 32'hffffffff)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (sel_br && flush_cnt_o != 32'hffffffff)
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (MAX_WAIT=4).
// Counter expectations follow HAZARD_PERF_COUNT_EN.
module tb_hazard_controller;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic [31:0] IFID_ir_i;
  logic [31:0] IDEX_ir_i;
  logic [1:0]  IDEX_ctrl_mem_read_i;
  logic        EXMEM_ctrl_branch_i;
  logic        EXMEM_alu_do_branch_i;
  logic [1:0]  EXMEM_ctrl_mem_read_i;
  logic [1:0]  EXMEM_ctrl_mem_write_i;
  logic        imem_ready_i;
  logic        dmem_ready_i;
  logic        pc_write_o;
  logic        pc_src_o;
  logic        IFID_write_o;
  logic        IFID_flush_o;
  logic        IDEX_write_o;
  logic        IDEX_flush_o;
  logic        EXMEM_write_o;
  logic        EXMEM_flush_o;
  logic        MEMWB_write_o;
  logic        halt_o;
  logic        timeout_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  hazard_controller #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk_i                 (clk_i),
    .n_rst_i               (n_rst_i),
    .IFID_ir_i             (IFID_ir_i),
    .IDEX_ir_i             (IDEX_ir_i),
    .IDEX_ctrl_mem_read_i  (IDEX_ctrl_mem_read_i),
    .EXMEM_ctrl_branch_i   (EXMEM_ctrl_branch_i),
    .EXMEM_alu_do_branch_i (EXMEM_alu_do_branch_i),
    .EXMEM_ctrl_mem_read_i (EXMEM_ctrl_mem_read_i),
    .EXMEM_ctrl_mem_write_i(EXMEM_ctrl_mem_write_i),
    .imem_ready_i          (imem_ready_i),
    .dmem_ready_i          (dmem_ready_i),
    .pc_write_o            (pc_write_o),
    .pc_src_o              (pc_src_o),
    .IFID_write_o          (IFID_write_o),
    .IFID_flush_o          (IFID_flush_o),
    .IDEX_write_o          (IDEX_write_o),
    .IDEX_flush_o          (IDEX_flush_o),
    .EXMEM_write_o         (EXMEM_write_o),
    .EXMEM_flush_o         (EXMEM_flush_o),
    .MEMWB_write_o         (MEMWB_write_o),
    .halt_o                (halt_o),
    .timeout_o             (timeout_o),
    .stall_cnt_o           (stall_cnt_o),
    .flush_cnt_o           (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {pc_wr, pc_src, ifid_wr, ifid_fl, idex_wr, idex_fl, exmem_wr, exmem_fl, memwb_wr}
  localparam logic [8:0] NORM = 9'b1_0_1_0_1_0_1_0_1;
  localparam logic [8:0] FRZ  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] BR   = 9'b1_1_1_1_1_1_1_1_1;
  localparam logic [8:0] LU   = 9'b0_0_0_0_1_1_1_0_1;
  localparam logic [8:0] IFS  = 9'b0_0_1_1_1_0_1_0_1;

  localparam logic [31:0] ADD_NH = {6'd0, 5'd3, 5'd4, 5'd5, 11'h20};
  localparam logic [31:0] LW2    = {6'h23, 5'd1, 5'd2, 16'd0};
  localparam logic [31:0] LW0    = {6'h23, 5'd1, 5'd0, 16'd0};
  localparam logic [31:0] USE_RS = {6'd0, 5'd2, 5'd1, 5'd3, 11'h20};
  localparam logic [31:0] USE_RT = {6'd0, 5'd5, 5'd2, 5'd3, 11'h20};
  localparam logic [31:0] ZERO_R = {6'd0, 5'd0, 5'd0, 5'd3, 11'h20};

  typedef struct {
    string       name;
    logic [8:0]  ctrl;
    logic        halt;
    logic        tmo;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests  = 0;
  int   failed = 0;
  logic [8:0] act;

  function automatic logic [31:0] pc(input int v);
`ifdef HAZARD_PERF_COUNT_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd1;
`endif
  endfunction

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      act = {pc_write_o, pc_src_o, IFID_write_o, IFID_flush_o,
             IDEX_write_o, IDEX_flush_o, EXMEM_write_o,
             EXMEM_flush_o, MEMWB_write_o};
      if (act !== e.ctrl || halt_o !== e.halt || timeout_o !== e.tmo ||
          stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
        failed++;
        $display("FAIL %s: got ctrl=%b halt=%b to=%b sc=%0d fc=%0d, want ctrl=%b halt=%b to=%b sc=%0d fc=%0d",
                 e.name, act, halt_o, timeout_o, stall_cnt_o, flush_cnt_o,
                 e.ctrl, e.halt, e.tmo, e.sc, e.fc);
      end
    end
  end

  task automatic idle();
    IFID_ir_i              = ADD_NH;
    IDEX_ir_i              = 32'd0;
    IDEX_ctrl_mem_read_i   = 2'd0;
    EXMEM_ctrl_branch_i    = 1'b0;
    EXMEM_alu_do_branch_i  = 1'b0;
    EXMEM_ctrl_mem_read_i  = 2'd0;
    EXMEM_ctrl_mem_write_i = 2'd0;
    imem_ready_i           = 1'b1;
    dmem_ready_i           = 1'b1;
  endtask

  task automatic step(input string nm, input logic [8:0] c,
                      input logic h, input logic t,
                      input int sc, input int fc);
    exp_t x;
    x.name = nm;
    x.ctrl = c;
    x.halt = h;
    x.tmo  = t;
    x.sc   = pc(sc);
    x.fc   = pc(fc);
    q.push_back(x);
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_use_rs();
    IDEX_ir_i            = LW2;
    IDEX_ctrl_mem_read_i = 2'd1;
    IFID_ir_i            = USE_RS;
  endtask

  initial begin
    n_rst_i = 1'b0;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    step("reset", NORM, 0, 0, 0, 0);
    n_rst_i = 1'b1;
    step("idle0", NORM, 0, 0, 0, 0);

    load_use_rs();
    step("lu_rs", LU, 0, 0, 0, 0);
    idle();
    step("lu_rel", NORM, 0, 0, 1, 0);
    load_use_rs();
    IFID_ir_i = USE_RT;
    step("lu_rt", LU, 0, 0, 1, 0);
    idle();
    step("idle1", NORM, 0, 0, 2, 0);
    IDEX_ir_i = LW0;
    IDEX_ctrl_mem_read_i = 2'd1;
    IFID_ir_i = ZERO_R;
    step("lw_r0", NORM, 0, 0, 2, 0);
    idle();
    EXMEM_ctrl_branch_i = 1'b1;
    step("br_nt", NORM, 0, 0, 2, 0);
    load_use_rs();
    EXMEM_alu_do_branch_i = 1'b1;
    step("br_lu", BR, 0, 0, 2, 0);
    idle();
    step("br_rel", NORM, 0, 0, 2, 1);

    EXMEM_ctrl_mem_write_i = 2'd1;
    dmem_ready_i = 1'b0;
    step("st_w1", FRZ, 0, 0, 2, 1);
    step("st_w2", FRZ, 0, 0, 3, 1);
    step("st_w3", FRZ, 0, 0, 4, 1);
    dmem_ready_i = 1'b1;
    step("st_done", NORM, 0, 0, 5, 1);
    idle();
    step("idle2", NORM, 0, 0, 5, 1);

    imem_ready_i = 1'b0;
    step("if_w1", IFS, 0, 0, 5, 1);
    step("if_w2", IFS, 0, 0, 6, 1);
    idle();
    step("if_rel", NORM, 0, 0, 7, 1);
    imem_ready_i = 1'b0;
    EXMEM_ctrl_branch_i = 1'b1;
    EXMEM_alu_do_branch_i = 1'b1;
    step("br_if", BR, 0, 0, 7, 1);
    idle();
    step("idle3", NORM, 0, 0, 7, 2);

    EXMEM_ctrl_mem_read_i = 2'd1;
    dmem_ready_i = 1'b0;
    for (int i = 0; i < 5; i++)
      step($sformatf("to_w%0d", i + 1), FRZ, 0, 0, 7 + i, 2);
    idle();
    step("halt", FRZ, 1, 1, 12, 2);
    EXMEM_ctrl_branch_i = 1'b1;
    EXMEM_alu_do_branch_i = 1'b1;
    step("halt_br", FRZ, 1, 1, 12, 2);

    idle();
    n_rst_i = 1'b0;
    step("rst_halt", NORM, 0, 0, 0, 0);
    n_rst_i = 1'b1;
    step("post_rst", NORM, 0, 0, 0, 0);

    EXMEM_ctrl_mem_write_i = 2'd2;
    dmem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      step($sformatf("max_w%0d", i + 1), FRZ, 0, 0, i, 0);
    dmem_ready_i = 1'b1;
    EXMEM_ctrl_branch_i = 1'b1;
    EXMEM_alu_do_branch_i = 1'b1;
    step("max_rel_br", BR, 0, 0, 4, 0);
    idle();
    step("idle4", NORM, 0, 0, 4, 1);

    EXMEM_ctrl_mem_read_i = 2'd2;
    dmem_ready_i = 1'b0;
    step("mw1", FRZ, 0, 0, 4, 1);
    step("mw2", FRZ, 0, 0, 5, 1);
    n_rst_i = 1'b0;
    step("rst_wait", FRZ, 0, 0, 0, 0);
    n_rst_i = 1'b1;
    idle();
    step("rst_rel", NORM, 0, 0, 0, 0);
    step("idle5", NORM, 0, 0, 0, 0);

    @(negedge clk_i);
    #1;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
